// File: rtl/m68k_bus_snapshot_if.sv
// Signal bundle between the 68000 pins / SPI monitor and m68k_bus_snapshot.
// The master side drives the CPU bus and the monitor control byte; the slave side is the snapshot block.
interface m68k_bus_snapshot_if;
  logic        AS_N_IN;
  logic        UDS_N_IN;
  logic        LDS_N_IN;
  logic        RW_IN;
  logic [22:0] ADDR_IN;
  logic [15:0] DATA_IN;
  logic [7:0]  CONTROL_IN;
  logic [23:0] SNAP_ADDR;
  logic [15:0] SNAP_DATA;
  logic [7:0]  SNAP_SIGNAL;
  logic        DTACK_N;

  modport master (
    output AS_N_IN, UDS_N_IN, LDS_N_IN, RW_IN, ADDR_IN, DATA_IN, CONTROL_IN,
    input  SNAP_ADDR, SNAP_DATA, SNAP_SIGNAL, DTACK_N
  );

  modport slave (
    input  AS_N_IN, UDS_N_IN, LDS_N_IN, RW_IN, ADDR_IN, DATA_IN, CONTROL_IN,
    output SNAP_ADDR, SNAP_DATA, SNAP_SIGNAL, DTACK_N
  );
endinterface

// File: rtl/m68k_bus_snapshot.sv
// Captures each 68000 bus cycle into a stable snapshot for the SPI monitor and
// withholds DTACK in single-step mode until the host grants a step.
module m68k_bus_snapshot #(
  parameter int unsigned SETTLE_CYCLES = 2,  // 1..15
  parameter int unsigned SYNC_STAGES   = 2   // 2..3
) (
  input  logic               CLK_IN,
  input  logic               RESET_IN,
  m68k_bus_snapshot_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE    = 2'd1,
    WAIT_STEP = 2'd2,
    ACK       = 2'd3
  } state_e;

  // Strobe lanes: [0] AS_N, [1] UDS_N, [2] LDS_N. Control lanes: [0] STEP_MODE, [1] STEP, [2] FREEZE.
  logic [SYNC_STAGES-1:0][2:0] strb_sync_q;
  logic [SYNC_STAGES-1:0][2:0] ctrl_sync_q;
  logic [2:0]  strb_s;
  logic [2:0]  ctrl_s;
  logic        as_n_s, uds_n_s, lds_n_s;
  logic        step_mode_s, step_tgl_s, freeze_s;
  logic        step_prev_q;
  logic        step_grant;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dtack_n_q, dtack_n_d;
  logic        capture;

  logic [23:0] snap_addr_q;
  logic [15:0] snap_data_q;
  logic [2:0]  snap_lo_q;
  logic [2:0]  seq_q;

  logic [4:0]  unused_ctrl;
  assign unused_ctrl = bus.CONTROL_IN[7:3];

  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would chain the sync stages into one.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      strb_sync_q <= '1;
      ctrl_sync_q <= '0;
      step_prev_q <= 1'b0;
    end else begin
      strb_sync_q <= {strb_sync_q[SYNC_STAGES-2:0], {bus.LDS_N_IN, bus.UDS_N_IN, bus.AS_N_IN}};
      ctrl_sync_q <= {ctrl_sync_q[SYNC_STAGES-2:0], bus.CONTROL_IN[2:0]};
      step_prev_q <= ctrl_s[1];
    end
  end

  assign strb_s      = strb_sync_q[SYNC_STAGES-1];
  assign ctrl_s      = ctrl_sync_q[SYNC_STAGES-1];
  assign as_n_s      = strb_s[0];
  assign uds_n_s     = strb_s[1];
  assign lds_n_s     = strb_s[2];
  assign step_mode_s = ctrl_s[0];
  assign step_tgl_s  = ctrl_s[1];
  assign freeze_s    = ctrl_s[2];
  // Either edge of the toggle is a grant; it only matters in WAIT_STEP, so grants elsewhere are lost.
  assign step_grant  = step_tgl_s ^ step_prev_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!as_n_s && (!uds_n_s || !lds_n_s)) begin
          state_d = SETTLE;
          cnt_d   = 4'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        if (as_n_s) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          capture = !freeze_s;
          state_d = step_mode_s ? WAIT_STEP : ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WAIT_STEP: begin
        if (as_n_s)                         state_d = IDLE;
        else if (step_grant || !step_mode_s) state_d = ACK;
      end
      ACK: begin
        if (as_n_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dtack_n_d = (state_d != ACK);
  end

  // NOTE: the snapshot registers are reset too, because the host may read them over SPI before the first bus cycle.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dtack_n_q   <= 1'b1;
      snap_addr_q <= '0;
      snap_data_q <= '0;
      snap_lo_q   <= '0;
      seq_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dtack_n_q <= dtack_n_d;
      if (capture) begin
        snap_addr_q <= {bus.ADDR_IN, 1'b0};
        snap_data_q <= bus.DATA_IN;
        snap_lo_q   <= {lds_n_s, uds_n_s, bus.RW_IN};
        seq_q       <= seq_q + 3'd1;
      end
    end
  end

  assign bus.SNAP_ADDR   = snap_addr_q;
  assign bus.SNAP_DATA   = snap_data_q;
  assign bus.SNAP_SIGNAL = {seq_q, step_mode_s, (state_q == WAIT_STEP), snap_lo_q};
  assign bus.DTACK_N     = dtack_n_q;

endmodule

// File: tb/tb_m68k_bus_snapshot.sv
// Self-checking bench for m68k_bus_snapshot: expected snapshots are queued when a
// bus cycle is driven and popped when the DUT acknowledges or stalls it.
module tb_m68k_bus_snapshot;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic [2:0]  lo;
    logic [2:0]  seq;
  } snap_t;

  snap_t exp_q[$];
  snap_t model;

  always #5 clk = ~clk;

  m68k_bus_snapshot_if bus_if();

  m68k_bus_snapshot #(.SETTLE_CYCLES(2), .SYNC_STAGES(2)) dut (
    .CLK_IN   (clk),
    .RESET_IN (rst),
    .bus      (bus_if.slave)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    model.addr = '0;
    model.data = '0;
    model.lo   = '0;
    model.seq  = '0;
    exp_q.delete();
  endtask

  task automatic idle_bus();
    bus_if.AS_N_IN  = 1'b1;
    bus_if.UDS_N_IN = 1'b1;
    bus_if.LDS_N_IN = 1'b1;
    bus_if.RW_IN    = 1'b1;
    bus_if.ADDR_IN  = '0;
    bus_if.DATA_IN  = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_bus();
    bus_if.CONTROL_IN = 8'h00;
    reset_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one bus cycle at posedge+1 and queues the snapshot the block should hold afterwards.
  task automatic start_cycle(input logic [23:0] addr, input logic [15:0] data,
                             input logic rw, input logic uds_n, input logic lds_n);
    @(posedge clk);
    #1;
    bus_if.ADDR_IN  = addr[23:1];
    bus_if.DATA_IN  = data;
    bus_if.RW_IN    = rw;
    bus_if.UDS_N_IN = uds_n;
    bus_if.LDS_N_IN = lds_n;
    bus_if.AS_N_IN  = 1'b0;
    if (!bus_if.CONTROL_IN[2]) begin
      model.addr = {addr[23:1], 1'b0};
      model.data = data;
      model.lo   = {lds_n, uds_n, rw};
      model.seq  = model.seq + 3'd1;
    end
    exp_q.push_back(model);
  endtask

  task automatic wait_dtack(input logic level, input int max, output int n);
    int i;
    i = 0;
    n = -1;
    while (n < 0 && i < max) begin
      i++;
      tick(1);
      if (bus_if.DTACK_N === level) n = i;
    end
  endtask

  task automatic wait_stall(input int max, output int n);
    int i;
    i = 0;
    n = -1;
    while (n < 0 && i < max) begin
      i++;
      tick(1);
      if (bus_if.SNAP_SIGNAL[3] === 1'b1) n = i;
    end
  endtask

  task automatic end_cycle(output int n);
    idle_bus();
    wait_dtack(1'b1, 3, n);
  endtask

  task automatic pop_expected(output snap_t e, output bit ok);
    ok = (exp_q.size() != 0);
    if (ok) e = exp_q.pop_front();
    else    e = model;
  endtask

  task automatic count_dtack_lows(input int cycles, output int lows);
    lows = 0;
    repeat (cycles) begin
      tick(1);
      if (bus_if.DTACK_N !== 1'b1) lows++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus_if.DTACK_N !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dtack: DTACK_N=%b, expected 1", bus_if.DTACK_N);
    end
    n_checks++;
    if ({bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_snap: addr=%h data=%h sig=%h, expected all 0",
               bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL);
    end
  endtask

  task automatic test_read_cycle();
    int n; snap_t e; bit ok; logic [7:0] es;
    start_cycle(24'h123456, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    wait_dtack(1'b0, 20, n);
    n_checks++;
    if (n !== 6) begin
      n_fail++;
      $display("FAIL read_latency: DTACK low after %0d clocks, expected 6", n);
    end
    pop_expected(e, ok);
    es = {e.seq, 1'b0, 1'b0, e.lo};
    n_checks++;
    if (!ok || {bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL} !== {e.addr, e.data, es}) begin
      n_fail++;
      $display("FAIL read_snap: got %h/%h/%h, expected %h/%h/%h", bus_if.SNAP_ADDR,
               bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL, e.addr, e.data, es);
    end
    n_checks++;
    if (bus_if.SNAP_ADDR !== 24'h123456 || bus_if.SNAP_DATA !== 16'hBEEF || bus_if.SNAP_SIGNAL !== 8'h21) begin
      n_fail++;
      $display("FAIL read_literal: got %h/%h/%h, expected 123456/beef/21",
               bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL);
    end
    end_cycle(n);
    n_checks++;
    if (n < 0) begin
      n_fail++;
      $display("FAIL read_release: DTACK_N=%b 3 clocks after AS_N rose, expected 1", bus_if.DTACK_N);
    end
  endtask

  task automatic test_step_mode();
    int n; int lows; snap_t e; bit ok; logic [7:0] es;
    bus_if.CONTROL_IN = 8'h01;
    tick(4);
    start_cycle(24'h00A000, 16'h00A5, 1'b0, 1'b1, 1'b0);
    wait_stall(20, n);
    n_checks++;
    if (n < 0) begin
      n_fail++;
      $display("FAIL step_stall: SNAP_SIGNAL[3]=%b after 20 clocks, expected 1", bus_if.SNAP_SIGNAL[3]);
    end
    pop_expected(e, ok);
    es = {e.seq, 1'b1, 1'b1, e.lo};
    n_checks++;
    if (!ok || {bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL} !== {e.addr, e.data, es}) begin
      n_fail++;
      $display("FAIL step_snap: got %h/%h/%h, expected %h/%h/%h", bus_if.SNAP_ADDR,
               bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL, e.addr, e.data, es);
    end
    count_dtack_lows(100, lows);
    n_checks++;
    if (lows !== 0) begin
      n_fail++;
      $display("FAIL step_hold: DTACK low on %0d of 100 clocks, expected 0", lows);
    end
    bus_if.CONTROL_IN = 8'h03;
    wait_dtack(1'b0, 5, n);
    n_checks++;
    if (n < 0) begin
      n_fail++;
      $display("FAIL step_grant: DTACK_N=%b 5 clocks after STEP toggle, expected 0", bus_if.DTACK_N);
    end
    n_checks++;
    if (bus_if.SNAP_SIGNAL[4:3] !== 2'b10) begin
      n_fail++;
      $display("FAIL step_flags: SNAP_SIGNAL[4:3]=%b, expected 10", bus_if.SNAP_SIGNAL[4:3]);
    end
    end_cycle(n);
    n_checks++;
    if (n < 0) begin
      n_fail++;
      $display("FAIL step_release: DTACK_N=%b after release, expected 1", bus_if.DTACK_N);
    end
    bus_if.CONTROL_IN = 8'h00;
    tick(4);
  endtask

  task automatic test_freeze();
    int n; snap_t e; bit ok; logic [7:0] es;
    bus_if.CONTROL_IN = 8'h04;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      start_cycle(24'h200000 + 24'(i) * 24'h002468, 16'h1111 * 16'(i + 1), 1'b1, 1'b0, 1'b0);
      wait_dtack(1'b0, 20, n);
      n_checks++;
      if (n !== 6) begin
        n_fail++;
        $display("FAIL freeze_ack%0d: DTACK low after %0d clocks, expected 6", i, n);
      end
      pop_expected(e, ok);
      es = {e.seq, 1'b0, 1'b0, e.lo};
      n_checks++;
      if (!ok || {bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL} !== {e.addr, e.data, es}) begin
        n_fail++;
        $display("FAIL freeze_snap%0d: got %h/%h/%h, expected %h/%h/%h", i, bus_if.SNAP_ADDR,
                 bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL, e.addr, e.data, es);
      end
      end_cycle(n);
    end
    bus_if.CONTROL_IN = 8'h00;
    tick(4);
  endtask

  task automatic test_seq_wrap();
    int n; snap_t e; bit ok; logic [7:0] es;
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      start_cycle(24'h000100 * 24'(i), 16'hC000 + 16'(i), 1'(i % 2), 1'b0, 1'(i % 3 == 0));
      wait_dtack(1'b0, 20, n);
      pop_expected(e, ok);
      es = {e.seq, 1'b0, 1'b0, e.lo};
      n_checks++;
      if (n < 0 || !ok || {bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL} !== {e.addr, e.data, es}) begin
        n_fail++;
        $display("FAIL wrap_snap%0d: ack=%0d got %h/%h/%h, expected %h/%h/%h", i, n, bus_if.SNAP_ADDR,
                 bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL, e.addr, e.data, es);
      end
      n_checks++;
      if (bus_if.SNAP_SIGNAL[7:5] !== 3'(i)) begin
        n_fail++;
        $display("FAIL wrap_seq%0d: seq=%0d, expected %0d", i, bus_if.SNAP_SIGNAL[7:5], i % 8);
      end
      end_cycle(n);
    end
  endtask

  task automatic test_abort();
    int n; int lows; snap_t e; bit ok; logic [7:0] es;
    bus_if.CONTROL_IN = 8'h01;
    tick(4);
    start_cycle(24'h0ABCDE, 16'h5A5A, 1'b1, 1'b0, 1'b1);
    wait_stall(20, n);
    pop_expected(e, ok);
    es = {e.seq, 1'b1, 1'b1, e.lo};
    n_checks++;
    if (n < 0 || !ok || {bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL} !== {e.addr, e.data, es}) begin
      n_fail++;
      $display("FAIL abort_snap: stall=%0d got %h/%h/%h, expected %h/%h/%h", n, bus_if.SNAP_ADDR,
               bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL, e.addr, e.data, es);
    end
    idle_bus();
    count_dtack_lows(10, lows);
    n_checks++;
    if (lows !== 0 || bus_if.SNAP_SIGNAL[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: DTACK lows=%0d stalled=%b, expected 0 and 0", lows, bus_if.SNAP_SIGNAL[3]);
    end
    bus_if.CONTROL_IN = 8'h03;
    tick(6);
    start_cycle(24'h0ABCE0, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    wait_stall(20, n);
    pop_expected(e, ok);
    es = {e.seq, 1'b1, 1'b1, e.lo};
    n_checks++;
    if (n < 0 || !ok || {bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL} !== {e.addr, e.data, es}) begin
      n_fail++;
      $display("FAIL abort_next_snap: stall=%0d got %h/%h/%h, expected %h/%h/%h", n, bus_if.SNAP_ADDR,
               bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL, e.addr, e.data, es);
    end
    count_dtack_lows(30, lows);
    n_checks++;
    if (lows !== 0) begin
      n_fail++;
      $display("FAIL abort_no_early_ack: DTACK low on %0d of 30 clocks, expected 0", lows);
    end
    bus_if.CONTROL_IN = 8'h01;
    wait_dtack(1'b0, 5, n);
    n_checks++;
    if (n < 0) begin
      n_fail++;
      $display("FAIL abort_grant: DTACK_N=%b 5 clocks after STEP toggle, expected 0", bus_if.DTACK_N);
    end
    end_cycle(n);
    bus_if.CONTROL_IN = 8'h00;
    tick(4);
  endtask

  task automatic test_async_reset();
    int n; snap_t e; bit ok;
    start_cycle(24'h7FFFFE, 16'h1234, 1'b1, 1'b0, 1'b0);
    wait_dtack(1'b0, 20, n);
    pop_expected(e, ok);
    n_checks++;
    if (n !== 6 || !ok || bus_if.SNAP_ADDR !== e.addr || bus_if.SNAP_DATA !== e.data) begin
      n_fail++;
      $display("FAIL areset_pre: ack=%0d addr=%h data=%h, expected 6 %h %h", n,
               bus_if.SNAP_ADDR, bus_if.SNAP_DATA, e.addr, e.data);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus_if.DTACK_N !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_dtack: DTACK_N=%b right after reset, expected 1", bus_if.DTACK_N);
    end
    n_checks++;
    if ({bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL} !== 48'h0) begin
      n_fail++;
      $display("FAIL areset_snap: %h/%h/%h, expected all 0",
               bus_if.SNAP_ADDR, bus_if.SNAP_DATA, bus_if.SNAP_SIGNAL);
    end
    idle_bus();
    reset_model();
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1;
    idle_bus();
    bus_if.CONTROL_IN = 8'h00;
    test_reset();
    test_read_cycle();
    test_step_mode();
    test_freeze();
    test_seq_wrap();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
